// File: rtl/aion_burn_sequencer.sv
// Burn sequencer for a fusion shot: IDLE -> RAMP -> BURN -> (QUENCH) -> COOL -> IDLE.
// Samples plasma state over a valid/ready handshake. RAMP counts a dwell of hot samples
// before declaring burn. BURN watches beta, vertical position and alpha power, and
// quenches on any violation.
module aion_burn_sequencer #(
    parameter logic [31:0] TEMP_IGN     = 32'h000A_0000,
    parameter logic [31:0] BETA_MAX     = 32'h0002_8000,
    parameter logic [31:0] Z_LIMIT      = 32'h0000_0CCD,
    parameter int unsigned DWELL_N      = 16,
    parameter int unsigned RAMP_TIMEOUT = 1024,
    parameter int unsigned COOL_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        st_valid_i,
    output logic        st_ready_o,
    input  logic [31:0] temp_keV_i,
    input  logic [31:0] p_alpha_i,
    input  logic [31:0] beta_pol_i,
    input  logic [31:0] z_pos_i,
    output logic [2:0]  phase_o,
    output logic        heat_en_o,
    output logic        burn_active_o,
    output logic        quench_o,
    output logic [2:0]  fault_code_o,
    output logic [15:0] burn_cnt_o,
    output logic        done_o
);

    localparam int unsigned W_DWELL = $clog2(DWELL_N + 1);
    localparam int unsigned W_RAMP  = $clog2(RAMP_TIMEOUT + 1);
    localparam int unsigned W_COOL  = $clog2(COOL_CYCLES + 1);

    localparam logic [2:0] F_NONE  = 3'd0;
    localparam logic [2:0] F_ABORT = 3'd1;
    localparam logic [2:0] F_BETA  = 3'd2;
    localparam logic [2:0] F_VERT  = 3'd3;
    localparam logic [2:0] F_ALPHA = 3'd4;
    localparam logic [2:0] F_RAMP  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RAMP   = 3'd1,
        S_BURN   = 3'd2,
        S_QUENCH = 3'd3,
        S_COOL   = 3'd4
    } state_t;

    state_t              r_state;
    logic [W_DWELL-1:0]  r_dwell;
    logic [W_RAMP-1:0]   r_ramp_tmr;
    logic [W_COOL-1:0]   r_cool;

    state_t              w_state_nx;
    logic [2:0]          w_fault_nx;
    logic                w_done_nx;
    logic                w_accept;
    logic                w_hot;
    logic [31:0]         w_abs_z;
    logic                w_beta_trip;
    logic                w_z_trip;
    logic                w_alpha_trip;
    logic                w_dwell_done;
    logic                w_ramp_expired;
    logic                w_cool_done;

    // Sample qualification and limit comparisons (all fields signed Q16.16)
    assign w_accept       = st_valid_i & st_ready_o;
    assign w_hot          = $signed(temp_keV_i) >= $signed(TEMP_IGN);
    assign w_beta_trip    = $signed(beta_pol_i) > $signed(BETA_MAX);
    assign w_z_trip       = $signed(w_abs_z) > $signed(Z_LIMIT);
    assign w_alpha_trip   = $signed(p_alpha_i) <= 32'sd0;
    assign w_dwell_done   = (r_dwell == W_DWELL'(DWELL_N - 1));
    assign w_ramp_expired = (r_ramp_tmr == W_RAMP'(RAMP_TIMEOUT - 1));
    assign w_cool_done    = (r_cool == W_COOL'(COOL_CYCLES - 1));

    // |z| with the most negative value clamped so the result stays positive
    always_comb begin
        w_abs_z = z_pos_i;
        if (z_pos_i == 32'h8000_0000) begin
            w_abs_z = 32'h7FFF_FFFF;
        end else if (z_pos_i[31]) begin
            w_abs_z = 32'(-$signed(z_pos_i));
        end
    end

    // Next-state, fault and done decode; abort outranks every other cause
    always_comb begin
        w_state_nx = r_state;
        w_fault_nx = fault_code_o;
        w_done_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nx = S_RAMP;
                    w_fault_nx = F_NONE;
                end
            end
            S_RAMP: begin
                if (abort_i) begin
                    w_state_nx = S_QUENCH;
                    w_fault_nx = F_ABORT;
                end else if (w_accept && w_hot && w_dwell_done) begin
                    w_state_nx = S_BURN;
                end else if (w_ramp_expired) begin
                    w_state_nx = S_QUENCH;
                    w_fault_nx = F_RAMP;
                end
            end
            S_BURN: begin
                if (abort_i) begin
                    w_state_nx = S_QUENCH;
                    w_fault_nx = F_ABORT;
                end else if (w_accept && w_beta_trip) begin
                    w_state_nx = S_QUENCH;
                    w_fault_nx = F_BETA;
                end else if (w_accept && w_z_trip) begin
                    w_state_nx = S_QUENCH;
                    w_fault_nx = F_VERT;
                end else if (w_accept && w_alpha_trip) begin
                    w_state_nx = S_QUENCH;
                    w_fault_nx = F_ALPHA;
                end else if (!start_i) begin
                    w_state_nx = S_COOL;
                end
            end
            S_QUENCH: begin
                w_state_nx = S_COOL;
            end
            S_COOL: begin
                if (w_cool_done) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs, all driven from the decoded next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_dwell       <= '0;
            r_ramp_tmr    <= '0;
            r_cool        <= '0;
            phase_o       <= 3'd0;
            st_ready_o    <= 1'b0;
            heat_en_o     <= 1'b0;
            burn_active_o <= 1'b0;
            quench_o      <= 1'b0;
            fault_code_o  <= F_NONE;
            burn_cnt_o    <= 16'd0;
            done_o        <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            phase_o       <= 3'(w_state_nx);
            st_ready_o    <= (w_state_nx == S_RAMP) || (w_state_nx == S_BURN);
            heat_en_o     <= (w_state_nx == S_RAMP);
            burn_active_o <= (w_state_nx == S_BURN);
            quench_o      <= (w_state_nx == S_QUENCH);
            fault_code_o  <= w_fault_nx;
            done_o        <= w_done_nx;

            // A new shot starts from clean counters
            if (r_state == S_IDLE && w_state_nx == S_RAMP) begin
                r_dwell    <= '0;
                r_ramp_tmr <= '0;
                burn_cnt_o <= 16'd0;
            end else if (r_state == S_RAMP) begin
                r_ramp_tmr <= r_ramp_tmr + W_RAMP'(1);
                if (w_accept) begin
                    r_dwell <= w_hot ? (r_dwell + W_DWELL'(1)) : '0;
                end
            end else if (r_state == S_BURN) begin
                if (burn_cnt_o != 16'hFFFF) begin
                    burn_cnt_o <= burn_cnt_o + 16'd1;
                end
            end

            if (w_state_nx == S_COOL && r_state != S_COOL) begin
                r_cool <= '0;
            end else if (r_state == S_COOL) begin
                r_cool <= r_cool + W_COOL'(1);
            end
        end
    end

endmodule

// File: doc/aion_burn_sequencer.md
AION_BURN_SEQUENCER -- requirements
Module: aion_burn_sequencer

Interface
REQ-001 Parameter: TEMP_IGN, 32'h000A_0000 (10.0 keV, Q16.16), ignition temperature threshold.
REQ-002 Parameter: BETA_MAX, 32'h0002_8000 (2.5, Q16.16), beta_pol quench limit.
REQ-003 Parameter: Z_LIMIT, 32'h0000_0CCD (~0.05, Q16.16), vertical displacement limit on |z_pos|.
REQ-004 Parameter: DWELL_N, 16, consecutive accepted above-ignition samples required to enter BURN.
REQ-005 Parameter: RAMP_TIMEOUT, 1024, cycles allowed in RAMP before fault.
REQ-006 Parameter: COOL_CYCLES, 32, cycles spent in COOL.
REQ-007 Port: clk  in  1  sole clock, rising edge.
REQ-008 Port: rst  in  1  synchronous, active-high reset.
REQ-009 Port: start_i  in  1  level request to run a burn; deassertion during BURN requests a graceful stop.
REQ-010 Port: abort_i  in  1  immediate abort request.
REQ-011 Port: st_valid_i  in  1  plasma state sample valid.
REQ-012 Port: st_ready_o  out  1  sequencer accepts a sample this cycle.
REQ-013 Port: temp_keV_i, p_alpha_i, beta_pol_i, z_pos_i  in  32 each  signed Q16.16 sample fields.
REQ-014 Port: phase_o  out  3  state encoding: IDLE=0, RAMP=1, BURN=2, QUENCH=3, COOL=4.
REQ-015 Port: heat_en_o  out  1  auxiliary heating enable; burn_active_o  out  1; quench_o  out  1.
REQ-016 Port: fault_code_o  out  3  0 none, 1 abort, 2 beta, 3 vertical (z), 4 alpha loss, 5 ramp timeout.
REQ-017 Port: burn_cnt_o  out  16  cycles spent in BURN; done_o  out  1  end-of-sequence pulse.

Function
REQ-018 All outputs are registered; state and outputs update on the same clk edge, one cycle after the causing input.
REQ-019 Handshake: st_ready_o=1 in RAMP and BURN only; a sample is accepted iff st_valid_i & st_ready_o; non-accepted cycles leave dwell state unchanged.
REQ-020 IDLE: start_i=1 -> RAMP; on entry, fault_code_o, dwell counter, ramp timer and burn_cnt_o clear to 0.
REQ-021 RAMP: heat_en_o=1; accepted sample with temp_keV_i >= TEMP_IGN (signed) increments the dwell counter; accepted sample below threshold clears it to 0.
REQ-022 RAMP: the accepted sample that brings the dwell count to DWELL_N -> BURN.
REQ-023 RAMP: ramp timer counts every cycle; reaching RAMP_TIMEOUT without entering BURN -> QUENCH, fault 5.
REQ-024 BURN: burn_active_o=1, heat_en_o=0; burn_cnt_o increments each cycle and saturates at 16'hFFFF.
REQ-025 BURN fault checks on an accepted sample, priority: beta_pol_i > BETA_MAX -> fault 2; |z_pos_i| > Z_LIMIT -> fault 3; p_alpha_i <= 0 -> fault 4; any fault -> QUENCH.
REQ-026 |z_pos_i| is computed in 32 bits; input 32'h8000_0000 saturates to 32'h7FFF_FFFF.
REQ-027 BURN: start_i=0 with no fault in the same cycle -> COOL, fault_code_o stays 0.
REQ-028 abort_i=1 in RAMP or BURN -> QUENCH, fault 1; abort_i outranks all other faults and start_i; abort_i is ignored in IDLE, QUENCH and COOL.
REQ-029 QUENCH lasts exactly one cycle with quench_o=1 and heat_en_o=0, then -> COOL.
REQ-030 COOL: counter runs COOL_CYCLES cycles, then -> IDLE with done_o=1 for exactly one cycle; start_i is ignored in COOL.
REQ-031 fault_code_o is sticky from entry into QUENCH until the next IDLE->RAMP transition.
REQ-032 IDLE with start_i still high after done_o -> RAMP on the next cycle (back-to-back shots permitted).

Reset
REQ-033 rst=1 at a clk edge forces IDLE from any state: phase_o=0, all 1-bit outputs=0, fault_code_o=0, burn_cnt_o=0, all internal counters=0.
REQ-034 rst overrides start_i, abort_i and any sample accepted in the same cycle.

Verification
REQ-035 start_i=1, 16 valid samples temp=32'h000B_0000 -> phase_o=2 one cycle after the 16th acceptance; st_ready_o high throughout RAMP.
REQ-036 RAMP: 10 hot samples, 1 sample temp=32'h0009_0000, then 16 hot samples -> BURN only after the final 16; valid low gaps do not reset the count.
REQ-037 BURN: sample beta=32'h0003_0000 with z=32'h8000_0000 -> fault 2 (priority); quench_o pulses 1 cycle; COOL 32 cycles; done_o pulse.
REQ-038 BURN: abort_i=1 and start_i=0 in the same cycle -> QUENCH, fault 1 (not a graceful COOL).
REQ-039 RAMP with no valid samples for 1024 cycles -> QUENCH, fault 5; next start clears fault_code_o to 0.
REQ-040 rst asserted mid-BURN with burn_cnt_o=500 -> next cycle phase_o=0, burn_cnt_o=0, all outputs reset.
